// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: per-output-port wormhole switch allocator.
// Round-robin arbitration among N inputs, grant held from head to tail flit,
// selected flit registered into a single-entry valid/ready output stage.
// Optional build macro NOC_ARB_STALL_CNT_EN adds a saturating 16-bit
// output-stall counter port (stall_cnt).
//
// state  | meaning
// IDLE   | no packet owns the output; arbitrate among requesters this cycle
// LOCKED | grant held by one input until its tail flit is accepted

module noc_output_arbiter #(
  parameter int N         = 5,
  parameter int DataWidth = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N-1:0]                  in_valid,
  input  logic [N-1:0]                  in_tail,
  input  logic [N-1:0][DataWidth-1:0]   in_data,
  output logic [N-1:0]                  in_ready,
  output logic [N-1:0]                  grant,
  output logic                          out_valid,
  output logic [DataWidth-1:0]          out_data,
  output logic                          out_tail,
  input  logic                          out_ready
`ifdef NOC_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state, state_nx;
  logic [N-1:0]          grant_nx;
  logic [PW-1:0]         last, last_nx;
  logic [PW-1:0]         gidx, gidx_nx;
  logic [PW-1:0]         sel_idx;
  logic                  sel_found;
  logic                  can_accept;
  logic                  xfer;
  logic [DataWidth-1:0]  mux_data;
  logic                  mux_tail;

  // Round-robin pick: first requester scanning last+1, last+2, ... wrapping modulo N
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!sel_found && in_valid[j] && (j == (int'(last) + i) % N)) begin
          sel_found = 1'b1;
          sel_idx   = PW'(j);
        end
      end
    end
  end

  // Crossbar AND-OR mux driven by the one-hot grant; zero grant gives zero
  always_comb begin
    mux_data = '0;
    mux_tail = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (grant[j]) begin
        mux_data = mux_data | in_data[j];
        mux_tail = mux_tail | in_tail[j];
      end
    end
  end

  assign can_accept = !out_valid || out_ready;
  assign in_ready   = (state == LOCKED && can_accept) ? grant : '0;
  assign xfer       = |(in_valid & in_ready);

  // Next-state logic: arbitrate in IDLE, release the lock on an accepted tail
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    gidx_nx  = gidx;
    last_nx  = last;
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (sel_found) begin
          state_nx = LOCKED;
          gidx_nx  = sel_idx;
          for (int j = 0; j < N; j++) begin
            grant_nx[j] = (sel_idx == PW'(j));
          end
        end
      end
      LOCKED: begin
        if (xfer && mux_tail) begin
          state_nx = IDLE;
          grant_nx = '0;
          last_nx  = gidx;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= PW'(N - 1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      gidx  <= gidx_nx;
      last  <= last_nx;
    end
  end

  // Single-entry output stage: load on transfer, drain when downstream takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tail  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_tail  <= mux_tail;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef NOC_ARB_STALL_CNT_EN
  // Count cycles the output flit is blocked by downstream, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter (N=5, DataWidth=32).
// A packet-level reference model (owner index, pointer, output slot) predicts
// every cycle; directed tables/sequences add explicit expected constants.

module tb_noc_output_arbiter;

  localparam int N = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      iv, it;
  logic [N-1:0][31:0] idata;
  logic [N-1:0]      in_ready, grant;
  logic              out_valid, out_tail, ordy;
  logic [31:0]       out_data;

  noc_output_arbiter #(.N(N), .DataWidth(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_tail(it), .in_data(idata),
    .in_ready(in_ready), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_tail(out_tail),
    .out_ready(ordy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  int          m_owner;   // -1 when no packet owns the output
  int          m_last;
  logic        m_ov;
  logic [31:0] m_od;
  logic        m_ot;

  logic [N-1:0] cap_rdy;
  logic [31:0]  rx_q[$];

  typedef struct {
    logic [4:0]  v;
    logic [4:0]  t;
    logic [31:0] d;
    logic        rdy;
    logic [4:0]  e_rdy;
    logic [4:0]  e_grant;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ot;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [N-1:0][31:0] rep(input logic [31:0] x);
    logic [N-1:0][31:0] r;
    for (int j = 0; j < N; j++) r[j] = x;
    return r;
  endfunction

  // one clock cycle: drive, check in_ready, advance model, check registered outputs
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] t,
                      input logic [N-1:0][31:0] d, input logic rdy, input logic rst);
    int          n_owner, n_last;
    logic        n_ov, n_ot;
    logic [31:0] n_od;
    logic [N-1:0] e_rdy, e_gnt;
    bit          found;
    iv = v; it = t; idata = d; ordy = rdy; rst_n = rst;
    #1;
    e_rdy = '0;
    if (m_owner >= 0 && (!m_ov || rdy)) e_rdy[m_owner] = 1'b1;
    cap_rdy = in_ready;
    chk("in_ready", in_ready, e_rdy);
    if (out_valid && rdy) rx_q.push_back(out_data);

    n_owner = m_owner; n_last = m_last; n_ov = m_ov; n_od = m_od; n_ot = m_ot;
    if (!rst) begin
      n_owner = -1; n_last = N - 1; n_ov = 1'b0; n_od = '0; n_ot = 1'b0;
    end else if (m_owner >= 0) begin
      if (v[m_owner] && (!m_ov || rdy)) begin
        n_ov = 1'b1; n_od = d[m_owner]; n_ot = t[m_owner];
        if (t[m_owner]) begin
          n_owner = -1;
          n_last  = m_owner;
        end
      end else if (rdy) begin
        n_ov = 1'b0;
      end
    end else begin
      if (rdy) n_ov = 1'b0;
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && v[(m_last + k) % N]) begin
          found = 1;
          n_owner = (m_last + k) % N;
        end
      end
    end

    @(posedge clk);
    #1;
    m_owner = n_owner; m_last = n_last; m_ov = n_ov; m_od = n_od; m_ot = n_ot;
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    chk("grant", grant, e_gnt);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_tail", out_tail, m_ot);
    end
  endtask

  task automatic do_reset();
    step('0, '0, rep(32'h0), 1'b1, 1'b0);
  endtask

  logic [4:0]  fair_exp[12];
  logic [31:0] P[4];
  int          idx, c;

  initial begin
    m_owner = -1; m_last = N - 1; m_ov = 1'b0; m_od = '0; m_ot = 1'b0;
    iv = '0; it = '0; idata = '0; ordy = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    do_reset();
    chk("rst_grant", grant, 5'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tail", out_tail, 1'b0);

    // single requester, port 2, 3-flit packet
    tbl[0] = '{5'b00100, 5'b00000, 32'hAAAA0001, 1'b1, 5'b00000, 5'b00100, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{5'b00100, 5'b00000, 32'hAAAA0001, 1'b1, 5'b00100, 5'b00100, 1'b1, 32'hAAAA0001, 1'b0};
    tbl[2] = '{5'b00100, 5'b00000, 32'hAAAA0002, 1'b1, 5'b00100, 5'b00100, 1'b1, 32'hAAAA0002, 1'b0};
    tbl[3] = '{5'b00100, 5'b00100, 32'hAAAA0003, 1'b1, 5'b00100, 5'b00000, 1'b1, 32'hAAAA0003, 1'b1};
    tbl[4] = '{5'b00000, 5'b00000, 32'h0,        1'b1, 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0};
    for (int r = 0; r < 5; r++) begin
      step(tbl[r].v, tbl[r].t, rep(tbl[r].d), tbl[r].rdy, 1'b1);
      chk($sformatf("tbl%0d_in_ready", r), cap_rdy, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_grant", r), grant, tbl[r].e_grant);
      chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].e_ov);
      if (tbl[r].e_ov) begin
        chk($sformatf("tbl%0d_out_data", r), out_data, tbl[r].e_od);
        chk($sformatf("tbl%0d_out_tail", r), out_tail, tbl[r].e_ot);
      end
    end

    // round-robin fairness among ports 0,1,4 sending 1-flit packets
    fair_exp = '{5'b00001, 5'b0, 5'b00010, 5'b0, 5'b10000, 5'b0,
                 5'b00001, 5'b0, 5'b00010, 5'b0, 5'b10000, 5'b0};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(5'b10011, 5'b11111, rep(32'h1000 + k), 1'b1, 1'b1);
      chk($sformatf("fair_grant%0d", k), grant, fair_exp[k]);
    end

    // wormhole lock: port 3 holds through an in_valid gap while port 0 waits
    do_reset();
    step(5'b01000, 5'b0, rep(32'hC0), 1'b1, 1'b1);
    chk("worm_head_grant", grant, 5'b01000);
    step(5'b01001, 5'b0, rep(32'hC1), 1'b1, 1'b1);
    step(5'b01001, 5'b0, rep(32'hC2), 1'b1, 1'b1);
    step(5'b00001, 5'b0, rep(32'hEE), 1'b1, 1'b1);
    chk("worm_gap1_grant", grant, 5'b01000);
    step(5'b00001, 5'b0, rep(32'hEE), 1'b1, 1'b1);
    chk("worm_gap2_grant", grant, 5'b01000);
    step(5'b01001, 5'b0, rep(32'hC3), 1'b1, 1'b1);
    chk("worm_f3_grant", grant, 5'b01000);
    step(5'b01001, 5'b01000, rep(32'hC4), 1'b1, 1'b1);
    chk("worm_tail_grant", grant, 5'b00000);
    chk("worm_tail_data", out_data, 32'hC4);
    step(5'b00001, 5'b0, rep(32'hD0), 1'b1, 1'b1);
    chk("worm_next_grant", grant, 5'b00001);

    // backpressure: out_ready low for 4 cycles mid-packet on port 2
    P[0] = 32'hB0; P[1] = 32'hB1; P[2] = 32'hB2; P[3] = 32'hB3;
    do_reset();
    rx_q.delete();
    idx = 0; c = 0;
    while (idx < 4 && c < 20) begin
      step(5'b00100, (idx == 3) ? 5'b00100 : 5'b0, rep(P[idx]),
           !(c >= 3 && c <= 6), 1'b1);
      if (cap_rdy[2]) idx++;
      if (c >= 3 && c <= 6) begin
        chk("bp_in_ready_held", cap_rdy, 5'b0);
        chk("bp_out_valid_held", out_valid, 1'b1);
        chk("bp_out_data_held", out_data, P[1]);
        chk("bp_out_tail_held", out_tail, 1'b0);
      end
      c++;
    end
    chk("bp_all_accepted", idx, 4);
    step('0, '0, rep(32'h0), 1'b1, 1'b1);
    step('0, '0, rep(32'h0), 1'b1, 1'b1);
    chk("bp_rx_count", rx_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < rx_q.size()) chk($sformatf("bp_rx%0d", k), rx_q[k], P[k]);
    end

    // reset mid-packet on port 1
    do_reset();
    step(5'b00010, 5'b0, rep(32'hF1), 1'b1, 1'b1);
    step(5'b00010, 5'b0, rep(32'hF1), 1'b1, 1'b1);
    step(5'b00010, 5'b0, rep(32'hF2), 1'b1, 1'b0);
    chk("midrst_grant", grant, 5'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    step(5'b00110, 5'b0, rep(32'hF3), 1'b1, 1'b1);
    chk("midrst_rearb_grant", grant, 5'b00010);

    // port 4 tail accepted while port 0 requests: pointer wraps to 0
    do_reset();
    step(5'b10000, 5'b0, rep(32'h40), 1'b1, 1'b1);
    chk("wrap_p4_grant", grant, 5'b10000);
    step(5'b10001, 5'b10000, rep(32'h41), 1'b1, 1'b1);
    chk("wrap_tail_grant", grant, 5'b00000);
    step(5'b00001, 5'b0, rep(32'h42), 1'b1, 1'b1);
    chk("wrap_next_grant", grant, 5'b00001);

    // randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0][31:0] rd;
      for (int j = 0; j < N; j++) rd[j] = $urandom;
      step(N'($urandom_range(0, 31)), N'($urandom & $urandom),
           rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port wormhole switch allocator for the NoC router crossbar.
- Arbitrates among N input ports with round-robin priority.
- Drives a one-hot grant vector that is the crossbar one-hot mux select.
- Holds the grant from the head flit to the tail flit, then registers the selected flit into a single-entry output stage with valid/ready handshake.

Parameters:
- N, 5, number of input ports competing for this output; legal range 1..16.
- DataWidth, 32, flit payload width in bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  N  per-input flit valid.
- in_tail  input  N  per-input flag: the current flit is the last flit of its packet.
- in_data  input  N*DataWidth  per-input flit payload, packed as [N-1:0][DataWidth-1:0].
- in_ready  output  N  per-input accept; only the granted bit can be 1.
- grant  output  N  registered one-hot grant (crossbar mux select); all zero when idle.
- out_valid  output  1  output register holds a flit.
- out_data  output  DataWidth  output flit payload.
- out_tail  output  1  output flit is a tail flit.
- out_ready  input  1  downstream accepts the output flit.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, grant=0, out_valid=0, out_data=0, out_tail=0.
  - Round-robin pointer last=N-1, so port 0 has highest priority first.
  - Reset mid-packet abandons the packet immediately; no flush.
- can_accept = !out_valid || out_ready.
- State IDLE:
  - in_ready=0.
  - If any in_valid is set, select the first requesting index scanning last+1, last+2, ... modulo N.
  - Register grant=onehot(sel) and go to LOCKED. Arbitration costs exactly 1 cycle.
  - If no in_valid is set, stay in IDLE with grant=0.
- State LOCKED, with g = granted index:
  - in_ready[g] = can_accept; all other in_ready bits are 0.
  - A transfer occurs when in_valid[g] && in_ready[g]. On a transfer, out_data<=in_data[g], out_tail<=in_tail[g], out_valid<=1.
  - Transfer with in_tail[g]=1: next state IDLE, grant<=0, last<=g.
  - in_valid[g]=0 (bubble inside the packet): hold the grant indefinitely. Other requesters are never granted mid-packet.
- Output register:
  - When there is no transfer and out_ready=1, out_valid<=0.
  - out_valid=1 with out_ready=0 holds out_data and out_tail stable.
- Latency: a flit accepted at cycle t is presented at out_data in cycle t+1. One flit per cycle is sustained while out_ready=1.
- Tail handling:
  - A tail accept always returns to IDLE; the next arbitration happens the following cycle.
  - This gives one dead cycle between packets even when requests are pending.
- A single-flit packet (head flit with in_tail=1) locks for exactly one transfer.
- Invariants:
  - grant is always one-hot or zero, and in_ready is a subset of grant.
  - grant feeds the crossbar mux directly; zero grant yields a zero mux output.
- N=1: round-robin degenerates to always choosing port 0; the IDLE/LOCKED sequencing is unchanged.
- Pointer width is $clog2(N) with a minimum of 1; the modulo-N wrap is explicit for non-power-of-2 N.

Optional Feature:
- Macro: NOC_ARB_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits.
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0, saturates at 16'hFFFF, and resets to 0 on rst_n=0.
- When undefined: the port and counter are absent, and the rest of the behaviour is identical.

Test Plan:
- Single requester: N=5; port 2 sends a 3-flit packet (data A,B,C; tail on C) with out_ready=1.
  - grant=5'b00100 one cycle after in_valid rises.
  - out_data shows A,B,C on consecutive cycles, with out_tail=1 on C.
  - grant=0 the cycle after C is accepted.
- Round-robin fairness: ports 0, 1 and 4 each continuously send 1-flit packets after reset.
  - Grant order is 0,1,4,0,1,4, with one idle cycle between grants.
- Wormhole lock: port 3 sends a 4-flit packet with a 2-cycle in_valid gap after flit 2, while port 0 requests throughout.
  - grant stays 5'b01000 through the gap; port 0 is granted only after port 3's tail.
- Backpressure: out_ready=0 for 4 cycles mid-packet.
  - out_data and out_tail are held stable and in_ready[g]=0 while out_valid=1.
  - No flit is lost or duplicated after out_ready returns to 1.
  - With NOC_ARB_STALL_CNT_EN defined, stall_cnt=4.
- Reset mid-packet: assert rst_n=0 for one cycle during flit 2 of a port-1 packet.
  - Next cycle: grant=0, out_valid=0, state IDLE.
  - With ports 1 and 2 requesting, port 0 then has top priority; if port 0 is idle, port 1 wins.
- Simultaneous tail and requests: port 4's tail is accepted while port 0 is requesting.
  - Pointer wraps: the next grant is 5'b00001 two cycles after the tail accept.
